// File: rtl/nx_indirect_access_arb.sv
// Arbiter sharing one single-port table memory between N_HW hardware requesters and the
// software indirect-access port. Define NX_IA_ARB_STATS_EN to add software-grant statistics outputs.
module nx_indirect_access_arb #(
    parameter int unsigned N_HW        = 2,
    parameter int unsigned N_ADDR_BITS = 5,
    parameter int unsigned N_DATA_BITS = 32,
    parameter int unsigned SW_MAX_WAIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_HW-1:0]               hw_req,
    input  logic [N_HW-1:0]               hw_we,
    input  logic [N_HW-1:0]               hw_lock,
    input  logic [N_HW*N_ADDR_BITS-1:0]   hw_add,
    input  logic [N_HW*N_DATA_BITS-1:0]   hw_wdat,
    output logic [N_HW-1:0]               hw_gnt,
    output logic [N_HW-1:0]               hw_rvld,
    input  logic                          sw_cs,
    input  logic                          sw_ce,
    input  logic                          sw_we,
    input  logic [N_ADDR_BITS-1:0]        sw_add,
    input  logic [N_DATA_BITS-1:0]        sw_wdat,
    input  logic                          yield,
    output logic                          grant,
    output logic                          mem_cs,
    output logic                          mem_ce,
    output logic                          mem_we,
    output logic [N_ADDR_BITS-1:0]        mem_add,
    output logic [N_DATA_BITS-1:0]        mem_wdat,
    input  logic [N_DATA_BITS-1:0]        mem_rdat,
    output logic [N_DATA_BITS-1:0]        rdat
`ifdef NX_IA_ARB_STATS_EN
    ,
    output logic [15:0]                   stat_sw_gnt_cnt,
    output logic [15:0]                   stat_sw_force_cnt,
    output logic [3:0]                    stat_max_wait
`endif
);

    localparam int unsigned PTR_W  = (N_HW > 1) ? $clog2(N_HW) : 1;
    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SW_MAX_WAIT);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]   sw_wait_q, sw_wait_d;
    logic [N_HW-1:0]     hw_rvld_q, hw_rvld_d;

    logic                lock_act;
    logic                starve;
    logic                rr_hit;
    logic [PTR_W-1:0]    rr_idx;
    logic [PTR_W-1:0]    hw_idx;
    logic                hw_any;
    logic                sw_gnt;
    logic [N_HW-1:0]     hw_gnt_c;

    // (base + k) mod N_HW, with base < N_HW and k < N_HW
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_HW) begin
            s = s - N_HW;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin search upward from rr_ptr_q
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned k = 0; k < N_HW; k++) begin
            if (!rr_hit && hw_req[wrap_idx(rr_ptr_q, k)]) begin
                rr_hit = 1'b1;
                rr_idx = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    // State and lock-owner register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state: a locked grant enters/holds LOCKED; owner dropping its request releases at once
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (hw_any) begin
            if (hw_lock[hw_idx]) begin
                state_d = ST_LOCKED;
                owner_d = hw_idx;
            end else begin
                state_d = ST_ARB;
            end
        end else if (state_q == ST_LOCKED && !hw_req[owner_q]) begin
            state_d = ST_ARB;
        end
    end

    // Grant decision and memory mux; reset drops every grant asynchronously
    always_comb begin
        hw_gnt_c = '0;
        sw_gnt   = 1'b0;
        mem_cs   = 1'b0;
        mem_ce   = 1'b0;
        mem_we   = 1'b0;
        mem_add  = '0;
        mem_wdat = '0;
        lock_act = (state_q == ST_LOCKED) && hw_req[owner_q];
        starve   = (sw_wait_q == WAIT_MAX);
        hw_idx   = lock_act ? owner_q : rr_idx;

        if (!rst) begin
            if (yield && sw_cs) begin
                sw_gnt = 1'b1;
            end else if (lock_act) begin
                hw_gnt_c[owner_q] = 1'b1;
            end else if (sw_cs && starve) begin
                sw_gnt = 1'b1;
            end else if (rr_hit) begin
                hw_gnt_c[rr_idx] = 1'b1;
            end else if (sw_cs) begin
                sw_gnt = 1'b1;
            end
        end
        hw_any = |hw_gnt_c;

        if (sw_gnt) begin
            mem_cs   = 1'b1;
            mem_ce   = sw_ce;
            mem_we   = sw_we;
            mem_add  = sw_add;
            mem_wdat = sw_wdat;
        end else if (hw_any) begin
            mem_cs   = 1'b1;
            mem_we   = hw_we[hw_idx];
            mem_add  = hw_add[hw_idx*N_ADDR_BITS +: N_ADDR_BITS];
            mem_wdat = hw_wdat[hw_idx*N_DATA_BITS +: N_DATA_BITS];
        end
    end

    // Round-robin pointer, software starvation counter, read-valid pipeline
    always_comb begin
        rr_ptr_d  = hw_any ? wrap_idx(hw_idx, 1) : rr_ptr_q;
        hw_rvld_d = hw_gnt_c & ~hw_we;
        sw_wait_d = sw_wait_q;
        if (!sw_cs || sw_gnt) begin
            sw_wait_d = '0;
        end else if (sw_wait_q < WAIT_MAX) begin
            sw_wait_d = sw_wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            sw_wait_q <= '0;
            hw_rvld_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            sw_wait_q <= sw_wait_d;
            hw_rvld_q <= hw_rvld_d;
        end
    end

    assign hw_gnt  = hw_gnt_c;
    assign grant   = sw_gnt;
    assign hw_rvld = hw_rvld_q;
    assign rdat    = mem_rdat;

`ifdef NX_IA_ARB_STATS_EN
    logic [15:0] stat_gnt_q;
    logic [15:0] stat_force_q;
    logic [3:0]  stat_max_q;
    logic        sw_forced;

    // Yield and starvation in the same cycle count as a single forced grant
    assign sw_forced = sw_gnt && (yield || starve);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gnt_q   <= '0;
            stat_force_q <= '0;
            stat_max_q   <= '0;
        end else begin
            if (sw_gnt && stat_gnt_q != 16'hFFFF) begin
                stat_gnt_q <= stat_gnt_q + 16'd1;
            end
            if (sw_forced && stat_force_q != 16'hFFFF) begin
                stat_force_q <= stat_force_q + 16'd1;
            end
            if (sw_wait_q > stat_max_q) begin
                stat_max_q <= sw_wait_q;
            end
        end
    end

    assign stat_sw_gnt_cnt   = stat_gnt_q;
    assign stat_sw_force_cnt = stat_force_q;
    assign stat_max_wait     = stat_max_q;
`endif

endmodule

// File: tb/tb_nx_indirect_access_arb.sv
// Self-checking bench for nx_indirect_access_arb: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the grant rules and a shadow memory.
module tb_nx_indirect_access_arb;

    localparam int NH   = 2;
    localparam int NA   = 5;
    localparam int ND   = 32;
    localparam int MAXW = 4;
    localparam int HAW  = NH * NA;
    localparam int HDW  = NH * ND;

    logic            clk = 1'b0;
    logic            rst;
    logic [NH-1:0]   hw_req, hw_we, hw_lock;
    logic [HAW-1:0]  hw_add;
    logic [HDW-1:0]  hw_wdat;
    logic [NH-1:0]   hw_gnt, hw_rvld;
    logic            sw_cs, sw_ce, sw_we, yield;
    logic [NA-1:0]   sw_add;
    logic [ND-1:0]   sw_wdat;
    logic            grant, mem_cs, mem_ce, mem_we;
    logic [NA-1:0]   mem_add;
    logic [ND-1:0]   mem_wdat, mem_rdat, rdat;

    nx_indirect_access_arb #(
        .N_HW(NH), .N_ADDR_BITS(NA), .N_DATA_BITS(ND), .SW_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .hw_req(hw_req), .hw_we(hw_we), .hw_lock(hw_lock),
        .hw_add(hw_add), .hw_wdat(hw_wdat),
        .hw_gnt(hw_gnt), .hw_rvld(hw_rvld),
        .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
        .sw_add(sw_add), .sw_wdat(sw_wdat),
        .yield(yield), .grant(grant),
        .mem_cs(mem_cs), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_add(mem_add), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat), .rdat(rdat)
    );

    always #5 clk = ~clk;

    // Synchronous single-port table memory
    logic [ND-1:0] mem [2**NA];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_add] <= mem_wdat;
            else        mem_rdat     <= mem[mem_add];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [ND-1:0] shadow [2**NA];
    int            m_locked, m_owner, m_rr, m_wait;
    logic [NH-1:0] e_rvld;
    logic          rd_pend;
    logic [ND-1:0] exp_rdat;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_wait   = 0;
        e_rvld   = '0;
        rd_pend  = 1'b0;
        exp_rdat = '0;
    endtask

    task automatic set_idle();
        hw_req  = '0;
        hw_we   = '0;
        hw_lock = '0;
        hw_add  = {5'd7, 5'd3};
        hw_wdat = {32'h1111_1111, 32'h2222_2222};
        sw_cs   = 1'b0;
        sw_ce   = 1'b0;
        sw_we   = 1'b0;
        sw_add  = 5'h1F;
        sw_wdat = 32'h5555_AAAA;
        yield   = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances one clock, returns at negedge
    task automatic cycle();
        int            gs, gh, idx;
        logic [NH-1:0] e_gnt;
        logic          e_cs, e_ce, e_we;
        logic [NA-1:0] e_add;
        logic [ND-1:0] e_wdat;
        #1;
        gs = 0;
        gh = -1;
        if (yield && sw_cs) gs = 1;
        else if (m_locked != 0 && hw_req[m_owner]) gh = m_owner;
        else if (sw_cs && m_wait == MAXW) gs = 1;
        else begin
            for (int k = 0; k < NH; k++) begin
                idx = (m_rr + k) % NH;
                if (gh < 0 && hw_req[idx]) gh = idx;
            end
            if (gh < 0 && sw_cs) gs = 1;
        end

        e_gnt = '0;
        e_cs = 1'b0; e_ce = 1'b0; e_we = 1'b0; e_add = '0; e_wdat = '0;
        if (gs != 0) begin
            e_cs = 1'b1; e_ce = sw_ce; e_we = sw_we; e_add = sw_add; e_wdat = sw_wdat;
        end else if (gh >= 0) begin
            e_gnt[gh] = 1'b1;
            e_cs   = 1'b1;
            e_we   = hw_we[gh];
            e_add  = hw_add[gh*NA +: NA];
            e_wdat = hw_wdat[gh*ND +: ND];
        end

        check_val("hw_gnt",   64'(hw_gnt),   64'(e_gnt));
        check_val("grant",    64'(grant),    64'(gs));
        check_val("mem_cs",   64'(mem_cs),   64'(e_cs));
        check_val("mem_ce",   64'(mem_ce),   64'(e_ce));
        check_val("mem_we",   64'(mem_we),   64'(e_we));
        check_val("mem_add",  64'(mem_add),  64'(e_add));
        check_val("mem_wdat", 64'(mem_wdat), 64'(e_wdat));
        check_val("hw_rvld",  64'(hw_rvld),  64'(e_rvld));
        if (rd_pend) check_val("rdat", 64'(rdat), 64'(exp_rdat));

        @(posedge clk);
        if (gh >= 0) begin
            m_rr = (gh + 1) % NH;
            if (hw_lock[gh]) begin
                m_locked = 1;
                m_owner  = gh;
            end else begin
                m_locked = 0;
            end
        end else if (m_locked != 0 && !hw_req[m_owner]) begin
            m_locked = 0;
        end
        if (!sw_cs || gs != 0) m_wait = 0;
        else if (m_wait < MAXW) m_wait++;
        e_rvld  = (gh >= 0 && !hw_we[gh]) ? e_gnt : '0;
        rd_pend = e_cs && !e_we;
        if (rd_pend) exp_rdat = shadow[e_add];
        if (e_cs && e_we) shadow[e_add] = e_wdat;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2**NA; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[31]    = 32'hDEAD_BEEF;
        shadow[31] = 32'hDEAD_BEEF;

        set_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_hw_gnt",  64'(hw_gnt),  64'(0));
        check_val("rst_grant",   64'(grant),   64'(0));
        check_val("rst_mem_cs",  64'(mem_cs),  64'(0));
        check_val("rst_hw_rvld", 64'(hw_rvld), 64'(0));
        rst = 1'b0;

        // Round-robin alternation between two continuous readers
        hw_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 check_val("rr_alt", 64'(hw_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
            cycle();
        end

        // Software read of the top address
        set_idle();
        sw_cs = 1'b1;
        #1 check_val("sw_rd_cs", 64'(mem_cs), 64'(1));
        check_val("sw_rd_we", 64'(mem_we), 64'(0));
        cycle();
        sw_cs = 1'b0;
        #1 check_val("sw_rd_rdat", 64'(rdat), 64'hDEADBEEF);
        cycle();

        // Starvation force against a continuous hw0
        hw_req = 2'b01;
        sw_cs  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check_val("starve_grant", 64'(grant), (i == 4) ? 64'h1 : 64'h0);
            check_val("starve_hw_gnt", 64'(hw_gnt), (i == 4) ? 64'h0 : 64'h1);
            cycle();
        end

        // Locked burst by hw0, then hw1 gets its turn
        set_idle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            hw_req  = (i == 0) ? 2'b01 : 2'b11;
            hw_lock = (i < 3) ? 2'b01 : 2'b00;
            #1 check_val("burst_gnt", 64'(hw_gnt), (i < 4) ? 64'h1 : 64'h2);
            cycle();
        end

        // Yield breaks into an hw1 lock for one cycle without releasing it
        set_idle();
        hw_req  = 2'b10;
        hw_lock = 2'b10;
        cycle();
        sw_cs  = 1'b1;
        yield  = 1'b1;
        sw_add = 5'h0A;
        #1 check_val("yield_grant", 64'(grant), 64'(1));
        check_val("yield_add", 64'(mem_add), 64'h0A);
        check_val("yield_hw_gnt", 64'(hw_gnt), 64'(0));
        cycle();
        sw_cs = 1'b0;
        yield = 1'b0;
        #1 check_val("yield_resume", 64'(hw_gnt), 64'h2);
        cycle();

        // Reset while locked with an hw1 read outstanding
        #1 check_val("pre_rst_rvld", 64'(hw_rvld), 64'h2);
        rst = 1'b1;
        #1 check_val("mid_rst_hw_gnt", 64'(hw_gnt), 64'(0));
        check_val("mid_rst_grant",   64'(grant),   64'(0));
        check_val("mid_rst_rvld",    64'(hw_rvld), 64'(0));
        check_val("mid_rst_mem_cs",  64'(mem_cs),  64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        hw_req  = 2'b11;
        hw_lock = 2'b00;
        #1 check_val("post_rst_first", 64'(hw_gnt), 64'h1);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            hw_req  = NH'($urandom);
            hw_we   = NH'($urandom);
            hw_lock = NH'($urandom) & NH'($urandom);
            hw_add  = HAW'($urandom);
            hw_wdat = {$urandom, $urandom};
            sw_cs   = ($urandom_range(0, 2) != 0);
            sw_ce   = 1'($urandom);
            sw_we   = 1'($urandom);
            sw_add  = NA'($urandom);
            sw_wdat = $urandom;
            yield   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
